// File: rtl/key_event_decoder.sv
// Keypad event decoder: debounces the scanner's 12-bit key vector, turns each new
// single-key press into a 4-bit code and queues it for a valid/ready consumer.
module key_event_decoder #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [11:0]                 key,
  output logic                        code_valid,
  input  logic                        code_ready,
  output logic [3:0]                  code,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        multi_key,
  output logic                        overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  function automatic logic [3:0] popcount12(input logic [11:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 12; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  // Keypad layout: bits 0..8 are digits 1..9, then '*', '0', '#'.
  function automatic logic [3:0] encode_key(input logic [11:0] v);
    logic [3:0] c;
    c = 4'h0;
    for (int i = 0; i < 9; i++) if (v[i]) c = 4'(i + 1);
    if (v[9])  c = 4'hA;
    if (v[10]) c = 4'h0;
    if (v[11]) c = 4'hB;
    return c;
  endfunction

  logic [11:0]      key_q;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      stable;
  logic             commit;
  logic             press;
  logic             push;
  logic             pop;
  logic             drop;
  logic [3:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Sample stage: restart the count on any change of the raw vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      cnt   <= '0;
    end else if (key != key_q) begin
      key_q <= key;
      cnt   <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Commit stage: only a newly set lone key counts; chord shrinkage does not.
  assign commit = (key == key_q) && (cnt == CNT_MAX) && (key_q != stable);
  assign press  = commit && (popcount12(key_q) == 4'd1) && ((key_q & ~stable) != 12'h000);

  always_ff @(posedge clk) begin
    if (reset) begin
      stable    <= '0;
      multi_key <= 1'b0;
    end else if (commit) begin
      stable    <= key_q;
      multi_key <= (popcount12(key_q) >= 4'd2);
    end
  end

  // Code FIFO: a pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign code_valid = (count != '0);
  assign pop        = code_valid && code_ready;
  assign push       = press && ((count != FULL_CNT) || pop);
  assign drop       = press && (count == FULL_CNT) && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= encode_key(key_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W + 1)'(1);
      else if (pop && !push) count <= count - (PTR_W + 1)'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  assign code       = code_valid ? mem[rd_ptr] : 4'h0;
  assign fifo_count = count;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_key_event_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] key;
  logic        code_valid;
  logic        code_ready;
  logic [3:0]  code;
  logic [2:0]  fifo_count;
  logic        multi_key;
  logic        overflow;

  int checks = 0;
  int passes = 0;

  key_event_decoder #(.DEBOUNCE_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .key(key), .code_valid(code_valid),
    .code_ready(code_ready), .code(code), .fifo_count(fifo_count),
    .multi_key(multi_key), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input logic [11:0] k);
    key = k;
    step(6);
    key = 12'h000;
    step(6);
  endtask

  task automatic test_reset;
    reset = 1'b1; key = 12'h000; code_ready = 1'b0;
    step(2);
    reset = 1'b0;
    checks++; if (code_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", code_valid); else passes++;
    checks++; if (code !== 4'h0) $display("FAIL rst_code: got %0h want 0", code); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL rst_count: got %0d want 0", fifo_count); else passes++;
    checks++; if (multi_key !== 1'b0) $display("FAIL rst_multi: got %0b want 0", multi_key); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %0b want 0", overflow); else passes++;
  endtask

  task automatic test_single_press;
    logic seen;
    code_ready = 1'b1;
    key = 12'h010;
    step(4);
    checks++; if (code_valid !== 1'b0) $display("FAIL sp_early: got %0b want 0", code_valid); else passes++;
    step(1);
    checks++; if (code_valid !== 1'b1) $display("FAIL sp_valid: got %0b want 1", code_valid); else passes++;
    checks++; if (code !== 4'h5) $display("FAIL sp_code: got %0h want 5", code); else passes++;
    step(1);
    checks++; if (code_valid !== 1'b0) $display("FAIL sp_popped: got %0b want 0", code_valid); else passes++;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin step(1); seen |= code_valid; end
    key = 12'h000;
    for (int i = 0; i < 8; i++) begin step(1); seen |= code_valid; end
    checks++; if (seen !== 1'b0) $display("FAIL sp_release: got valid %0b want 0", seen); else passes++;
  endtask

  task automatic test_glitch;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key = (i % 2 == 0) ? 12'h001 : 12'h000;
      step(1); seen |= code_valid;
      step(1); seen |= code_valid;
    end
    key = 12'h000;
    for (int i = 0; i < 6; i++) begin step(1); seen |= code_valid; end
    checks++; if (seen !== 1'b0) $display("FAIL gl_valid: got %0b want 0", seen); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL gl_count: got %0d want 0", fifo_count); else passes++;
  endtask

  task automatic test_special_keys;
    code_ready = 1'b0;
    press_release(12'h200);
    press_release(12'h400);
    key = 12'h800;
    step(6);
    checks++; if (fifo_count !== 3'd3) $display("FAIL sk_count: got %0d want 3", fifo_count); else passes++;
    code_ready = 1'b1;
    checks++; if (code !== 4'hA) $display("FAIL sk_head0: got %0h want a", code); else passes++;
    step(1);
    checks++; if (code_valid !== 1'b1 || code !== 4'h0) $display("FAIL sk_head1: got v%0b %0h want v1 0", code_valid, code); else passes++;
    checks++; if (fifo_count !== 3'd2) $display("FAIL sk_count2: got %0d want 2", fifo_count); else passes++;
    step(1);
    checks++; if (code !== 4'hB) $display("FAIL sk_head2: got %0h want b", code); else passes++;
    step(1);
    checks++; if (code_valid !== 1'b0 || fifo_count !== 3'd0) $display("FAIL sk_empty: got v%0b n%0d want v0 n0", code_valid, fifo_count); else passes++;
    code_ready = 1'b0;
    key = 12'h000;
    step(6);
  endtask

  task automatic test_chord;
    code_ready = 1'b0;
    key = 12'h001;
    step(8);
    key = 12'h003;
    step(4);
    checks++; if (multi_key !== 1'b0) $display("FAIL ch_multi_pre: got %0b want 0", multi_key); else passes++;
    step(1);
    checks++; if (multi_key !== 1'b1) $display("FAIL ch_multi_on: got %0b want 1", multi_key); else passes++;
    step(3);
    key = 12'h001;
    step(5);
    checks++; if (multi_key !== 1'b0) $display("FAIL ch_multi_off: got %0b want 0", multi_key); else passes++;
    step(3);
    checks++; if (fifo_count !== 3'd1) $display("FAIL ch_count: got %0d want 1", fifo_count); else passes++;
    checks++; if (code !== 4'h1) $display("FAIL ch_code: got %0h want 1", code); else passes++;
    code_ready = 1'b1;
    step(1);
    code_ready = 1'b0;
    key = 12'h000;
    step(6);
  endtask

  task automatic test_overflow;
    code_ready = 1'b0;
    press_release(12'h001);
    press_release(12'h002);
    press_release(12'h004);
    press_release(12'h008);
    checks++; if (fifo_count !== 3'd4 || overflow !== 1'b0) $display("FAIL ov_full: got n%0d o%0b want n4 o0", fifo_count, overflow); else passes++;
    press_release(12'h010);
    checks++; if (fifo_count !== 3'd4) $display("FAIL ov_count: got %0d want 4", fifo_count); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ov_flag: got %0b want 1", overflow); else passes++;
    key = 12'h020;
    step(4);
    code_ready = 1'b1;
    step(1);
    code_ready = 1'b0;
    checks++; if (fifo_count !== 3'd4) $display("FAIL ov_pushpop_count: got %0d want 4", fifo_count); else passes++;
    checks++; if (code !== 4'h2) $display("FAIL ov_pushpop_head: got %0h want 2", code); else passes++;
    code_ready = 1'b1;
    step(1);
    checks++; if (code !== 4'h3) $display("FAIL ov_drain3: got %0h want 3", code); else passes++;
    step(1);
    checks++; if (code !== 4'h4) $display("FAIL ov_drain4: got %0h want 4", code); else passes++;
    step(1);
    checks++; if (code !== 4'h6) $display("FAIL ov_drain6: got %0h want 6", code); else passes++;
    step(1);
    checks++; if (code_valid !== 1'b0) $display("FAIL ov_empty: got %0b want 0", code_valid); else passes++;
    code_ready = 1'b0;
    key = 12'h000;
    step(6);
  endtask

  task automatic test_reset_mid;
    code_ready = 1'b0;
    press_release(12'h040);
    press_release(12'h080);
    checks++; if (fifo_count !== 3'd2) $display("FAIL rm_queued: got %0d want 2", fifo_count); else passes++;
    key = 12'h100;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++; if (code_valid !== 1'b0 || code !== 4'h0) $display("FAIL rm_valid: got v%0b %0h want v0 0", code_valid, code); else passes++;
    checks++; if (fifo_count !== 3'd0) $display("FAIL rm_count: got %0d want 0", fifo_count); else passes++;
    checks++; if (overflow !== 1'b0 || multi_key !== 1'b0) $display("FAIL rm_flags: got o%0b m%0b want 0 0", overflow, multi_key); else passes++;
    step(4);
    checks++; if (code_valid !== 1'b0) $display("FAIL rm_early: got %0b want 0", code_valid); else passes++;
    step(1);
    checks++; if (code_valid !== 1'b1 || code !== 4'h9) $display("FAIL rm_reissue: got v%0b %0h want v1 9", code_valid, code); else passes++;
  endtask

  initial begin
    reset = 1'b1; key = 12'h000; code_ready = 1'b0;
    test_reset;
    test_single_press;
    test_glitch;
    test_special_keys;
    test_chord;
    test_overflow;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
